spatz_issue_queue: RTL and testbench

- Sits between the Spatz decoder and the execution units (controller, VLSU, VSLDU, VFU).
- Buffers decoded `spatz_req_t` requests and stamps each with a free `spatz_id_t`.
- Presents them in order to the unit dispatch.
- Frees IDs when the owning unit returns its response, bounding in-flight instructions to `NrParallelInstructions`.

---
 rtl/spatz_issue_queue_pkg.sv | 54 +++++
 rtl/spatz_issue_queue_if.sv | 35 +++
 rtl/spatz_issue_queue_id_alloc.sv | 78 +++++++
 rtl/spatz_issue_queue.sv | 141 ++++++++++++++
 tb/tb_spatz_issue_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spatz_issue_queue_pkg.sv
// Types shared by the Spatz issue queue: decoded request, unit responses,
// instruction ID and ID mask, plus a one-hot helper.
package spatz_issue_queue_pkg;

    localparam int unsigned NrParallelInstructions = 4;
    localparam int unsigned IdWidth  = $clog2(NrParallelInstructions);
    localparam int unsigned NrRetire = 4;  // VFU, VLSU, VSLDU, controller

    typedef logic [IdWidth-1:0]                spatz_id_t;
    typedef logic [NrParallelInstructions-1:0] id_mask_t;
    typedef logic [4:0]                        vreg_t;

    typedef enum logic [1:0] {
        CON = 2'd0,
        VFU = 2'd1,
        LSU = 2'd2,
        SLD = 2'd3
    } ex_unit_e;

    typedef enum logic [2:0] {
        VCFG       = 3'd0,
        VADD       = 3'd1,
        VMUL       = 3'd2,
        VLE        = 3'd3,
        VSE        = 3'd4,
        VSLIDEUP   = 3'd5,
        VSLIDEDOWN = 3'd6
    } op_e;

    typedef struct packed {
        spatz_id_t   id;
        ex_unit_e    ex_unit;
        op_e         op;
        vreg_t       vd;
        vreg_t       vs1;
        vreg_t       vs2;
        logic        use_vd;
        logic        use_vs1;
        logic        use_vs2;
        logic [31:0] rs1;
    } spatz_req_t;

    // A queue entry is the request with its assigned id filled in.
    typedef spatz_req_t issue_entry_t;

    typedef struct packed { spatz_id_t id; } vfu_rsp_t;
    typedef struct packed { spatz_id_t id; } vlsu_rsp_t;
    typedef struct packed { spatz_id_t id; } vsldu_rsp_t;

    function automatic id_mask_t id_onehot(spatz_id_t id);
        return id_mask_t'(1) << id;
    endfunction

endpackage

// File: rtl/spatz_issue_queue_if.sv
// Decoder-side request, dispatch-side issue and unit response bundle of the
// issue queue. The queue uses the slave modport.
interface spatz_issue_queue_if;
    import spatz_issue_queue_pkg::*;

    logic       req_valid_i;
    logic       req_ready_o;
    spatz_req_t req_i;

    logic       issue_valid_o;
    logic       issue_ready_i;
    spatz_req_t issue_o;

    logic       vfu_rsp_valid_i;
    vfu_rsp_t   vfu_rsp_i;
    logic       vlsu_rsp_valid_i;
    vlsu_rsp_t  vlsu_rsp_i;
    logic       vsldu_rsp_valid_i;
    vsldu_rsp_t vsldu_rsp_i;

    modport master (
        output req_valid_i, req_i, issue_ready_i,
        output vfu_rsp_valid_i, vfu_rsp_i, vlsu_rsp_valid_i, vlsu_rsp_i,
        output vsldu_rsp_valid_i, vsldu_rsp_i,
        input  req_ready_o, issue_valid_o, issue_o
    );

    modport slave (
        input  req_valid_i, req_i, issue_ready_i,
        input  vfu_rsp_valid_i, vfu_rsp_i, vlsu_rsp_valid_i, vlsu_rsp_i,
        input  vsldu_rsp_valid_i, vsldu_rsp_i,
        output req_ready_o, issue_valid_o, issue_o
    );

endinterface

// File: rtl/spatz_issue_queue_id_alloc.sv
// Instruction ID allocator: owns the free mask, hands out the lowest free
// ID, frees IDs from several retire ports at once and reports the count of
// allocated IDs.
module spatz_issue_queue_id_alloc
    import spatz_issue_queue_pkg::*;
#(
    parameter int unsigned NrPorts  = NrRetire,
    parameter int unsigned CntWidth = $clog2(NrParallelInstructions + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        alloc_i,
    output spatz_id_t                   alloc_id_o,
    input  logic      [NrPorts-1:0]     retire_valid_i,
    input  spatz_id_t [NrPorts-1:0]     retire_id_i,
    output id_mask_t                    free_mask_o,
    output logic      [CntWidth-1:0]    in_flight_o
);

    id_mask_t              free_q;
    id_mask_t              free_d;
    id_mask_t              retire_mask;
    logic [CntWidth-1:0]   used_cnt;

    // Lowest-index free ID; only meaningful while some bit of free_q is set.
    always_comb begin
        alloc_id_o = '0;
        for (int i = int'(NrParallelInstructions) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_id_o = spatz_id_t'(i);
        end
    end

    // Merge all retire ports into one mask of IDs to free.
    always_comb begin
        retire_mask = '0;
        for (int p = 0; p < int'(NrPorts); p++) begin
            if (retire_valid_i[p]) retire_mask[retire_id_i[p]] = 1'b1;
        end
    end

    // Allocation always hits a free bit, so clearing and setting never collide.
    always_comb begin
        free_d = free_q | retire_mask;
        if (alloc_i) free_d = free_d & ~id_onehot(alloc_id_o);
    end

    // Free-mask register; every ID is free out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) free_q <= '1;
        else         free_q <= free_d;
    end

    // Count allocated IDs straight from the registered mask.
    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < int'(NrParallelInstructions); i++) begin
            if (!free_q[i]) used_cnt = used_cnt + 1'b1;
        end
    end

    assign free_mask_o = free_q;
    assign in_flight_o = used_cnt;

    // Retiring a free ID or the same ID on two ports is a protocol error.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int p = 0; p < int'(NrPorts); p++) begin
                if (retire_valid_i[p]) begin
                    assert (!free_q[retire_id_i[p]]);
                    for (int q = 0; q < p; q++) begin
                        if (retire_valid_i[q]) assert (retire_id_i[q] != retire_id_i[p]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spatz_issue_queue.sv
// Spatz issue queue: buffers decoded requests in a registered FIFO, stamps
// each with a free instruction ID and presents them in order to dispatch.
// IDs come back when the owning unit responds; controller requests free
// their ID at the issue handshake.
// Optional: SPATZ_ISSUE_HAZARD_STALL_EN holds the head back while it reads
// or writes a register still being written by an issued, unretired ID.
module spatz_issue_queue
    import spatz_issue_queue_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned NrIds = NrParallelInstructions
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    spatz_issue_queue_if.slave           bus,
    output logic [$clog2(NrIds+1)-1:0]   ids_in_flight_o,
    output logic                         busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    issue_entry_t              mem_q [Depth];
    logic         [PtrW-1:0]   wptr_q;
    logic         [PtrW-1:0]   rptr_q;
    logic         [CntW-1:0]   count_q;

    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      hazard;
    issue_entry_t              head;
    issue_entry_t              wr_entry;

    spatz_id_t                 alloc_id;
    id_mask_t                  free_mask;
    logic      [NrRetire-1:0]  retire_valid;
    spatz_id_t [NrRetire-1:0]  retire_id;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    // Ready looks only at registered state, never at issue_ready_i.
    assign bus.req_ready_o   = rst_ni && !full && (free_mask != '0);
    assign push              = bus.req_valid_i && bus.req_ready_o;
    assign bus.issue_valid_o = !empty && !hazard;
    assign pop               = bus.issue_valid_o && bus.issue_ready_i;
    assign bus.issue_o       = empty ? issue_entry_t'('0) : head;

    // Replace whatever id the decoder sent with the allocated one.
    always_comb begin
        wr_entry    = bus.req_i;
        wr_entry.id = alloc_id;
    end

    // Pointer and occupancy bookkeeping; pointers wrap, count tells full from empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; no bypass, so a new entry is seen the cycle after it is written.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wr_entry;
    end

    // Controller requests get no response and retire as they issue.
    assign retire_valid = {pop && (head.ex_unit == CON), bus.vsldu_rsp_valid_i,
                           bus.vlsu_rsp_valid_i, bus.vfu_rsp_valid_i};
    assign retire_id    = {head.id, bus.vsldu_rsp_i.id, bus.vlsu_rsp_i.id, bus.vfu_rsp_i.id};

    spatz_issue_queue_id_alloc #(
        .NrPorts  (NrRetire),
        .CntWidth ($clog2(NrIds + 1))
    ) i_id_alloc (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alloc_i        (push),
        .alloc_id_o     (alloc_id),
        .retire_valid_i (retire_valid),
        .retire_id_i    (retire_id),
        .free_mask_o    (free_mask),
        .in_flight_o    (ids_in_flight_o)
    );

    assign busy_o = !empty || (free_mask != '1);

`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
    vreg_t    vd_q [NrParallelInstructions];
    id_mask_t use_vd_q;
    id_mask_t issued_q;

    // Per-ID write flag and issued flag; a fresh allocation starts un-issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            use_vd_q <= '0;
            issued_q <= '0;
        end else begin
            if (pop) issued_q[head.id] <= 1'b1;
            if (push) begin
                use_vd_q[alloc_id] <= bus.req_i.use_vd;
                issued_q[alloc_id] <= 1'b0;
            end
        end
    end

    // Destination register of each allocated ID.
    always_ff @(posedge clk_i) begin
        if (push) vd_q[alloc_id] <= bus.req_i.vd;
    end

    // Stall while the head touches a vd still owned by another issued ID.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(NrParallelInstructions); i++) begin
            if ((spatz_id_t'(i) != head.id) && !free_mask[i] && issued_q[i] && use_vd_q[i] &&
                ((head.use_vs1 && (head.vs1 == vd_q[i])) ||
                 (head.use_vs2 && (head.vs2 == vd_q[i])) ||
                 (head.use_vd  && (head.vd  == vd_q[i])))) begin
                hazard = 1'b1;
            end
        end
    end
`else
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_spatz_issue_queue.sv
// Bench for spatz_issue_queue: directed scenarios followed by random traffic,
// checked by a reference model of the queue/ID rules and an issue scoreboard.
module tb_spatz_issue_queue;
    import spatz_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int NIDS  = NrParallelInstructions;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ids_in_flight;
    logic       busy;

    spatz_issue_queue_if bus ();

    spatz_issue_queue #(.Depth(DEPTH), .NrIds(NIDS)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bus             (bus),
        .ids_in_flight_o (ids_in_flight),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    spatz_req_t      mq[$];        // expected queue contents, head first
    logic [NIDS-1:0] mfree = '1;   // model free IDs
    int              outst[$];     // issued, non-controller IDs awaiting a response
`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
    logic [4:0]      m_vd    [NIDS];
    bit              m_usevd [NIDS];
    bit              m_issued[NIDS] = '{default: 1'b0};
`endif

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_free();
        int n = 0;
        for (int i = 0; i < NIDS; i++) if (mfree[i]) n++;
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < NIDS; i++) if (mfree[i]) return i;
        return -1;
    endfunction

    function automatic bit head_blocked();
`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
        spatz_req_t h;
        if (mq.size() == 0) return 1'b0;
        h = mq[0];
        for (int i = 0; i < NIDS; i++) begin
            if (i != int'(h.id) && !mfree[i] && m_issued[i] && m_usevd[i] &&
                ((h.use_vs1 && h.vs1 == m_vd[i]) || (h.use_vs2 && h.vs2 == m_vd[i]) ||
                 (h.use_vd && h.vd == m_vd[i])))
                return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic model_free(int id);
        mfree[id] = 1'b1;
`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
        m_issued[id] = 1'b0;
`endif
    endtask

    // Monitor + model: compare outputs, then advance the model by one clock edge.
    always @(negedge clk) begin
        bit         exp_ready, exp_valid, acc, pop;
        int         aid;
        spatz_req_t h, e;
        if (!rst_n) begin
            chk("rst_issue_valid", 64'(bus.issue_valid_o), 64'(0));
            chk("rst_req_ready",   64'(bus.req_ready_o),   64'(0));
            chk("rst_in_flight",   64'(ids_in_flight),     64'(0));
            chk("rst_busy",        64'(busy),              64'(0));
            chk("rst_issue_o",     64'(bus.issue_o),       64'(0));
            mq.delete();
            outst.delete();
            for (int i = 0; i < NIDS; i++) model_free(i);
        end else begin
            exp_ready = (mq.size() < DEPTH) && (mfree != '0);
            exp_valid = (mq.size() != 0) && !head_blocked();
            chk("req_ready",   64'(bus.req_ready_o),   64'(exp_ready));
            chk("issue_valid", 64'(bus.issue_valid_o), 64'(exp_valid));
            chk("in_flight",   64'(ids_in_flight),     64'(NIDS - n_free()));
            chk("busy",        64'(busy),              64'((mq.size() != 0) || (mfree != '1)));
            if (exp_valid && bus.issue_valid_o)
                chk("issue_o", 64'(bus.issue_o), 64'(mq[0]));
            acc = bus.req_valid_i && exp_ready;
            pop = exp_valid && bus.issue_ready_i;
            aid = lowest_free();
            if (pop) begin
                h = mq.pop_front();
`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
                m_issued[h.id] = 1'b1;
`endif
                if (h.ex_unit == CON) model_free(int'(h.id));
                else                  outst.push_back(int'(h.id));
            end
            if (bus.vfu_rsp_valid_i)   model_free(int'(bus.vfu_rsp_i.id));
            if (bus.vlsu_rsp_valid_i)  model_free(int'(bus.vlsu_rsp_i.id));
            if (bus.vsldu_rsp_valid_i) model_free(int'(bus.vsldu_rsp_i.id));
            if (acc) begin
                e    = bus.req_i;
                e.id = spatz_id_t'(aid);
                mq.push_back(e);
                mfree[aid] = 1'b0;
`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
                m_vd[aid]     = e.vd;
                m_usevd[aid]  = e.use_vd;
                m_issued[aid] = 1'b0;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_rsp();
        bus.vfu_rsp_valid_i   = 1'b0;
        bus.vlsu_rsp_valid_i  = 1'b0;
        bus.vsldu_rsp_valid_i = 1'b0;
    endtask

    task automatic drive_rsp(int p, int id);
        case (p)
            0: begin bus.vfu_rsp_valid_i   = 1'b1; bus.vfu_rsp_i.id   = spatz_id_t'(id); end
            1: begin bus.vlsu_rsp_valid_i  = 1'b1; bus.vlsu_rsp_i.id  = spatz_id_t'(id); end
            default: begin bus.vsldu_rsp_valid_i = 1'b1; bus.vsldu_rsp_i.id = spatz_id_t'(id); end
        endcase
    endtask

    task automatic retire_id(int p, int id);
        int found = 0;
        for (int i = 0; i < outst.size(); i++) begin
            if (outst[i] == id) begin
                outst.delete(i);
                found = 1;
                break;
            end
        end
        chk("retire_target_outstanding", 64'(found), 64'(1));
        if (found != 0) drive_rsp(p, id);
    endtask

    task automatic retire_some(int prob);
        int idx, id;
        clr_rsp();
        for (int p = 0; p < 3; p++) begin
            if (outst.size() != 0 && $urandom_range(0, 99) < prob) begin
                idx = $urandom_range(0, outst.size() - 1);
                id  = outst[idx];
                outst.delete(idx);
                drive_rsp(p, id);
            end
        end
    endtask

    function automatic spatz_req_t mk(ex_unit_e ex, op_e op, int vd, int vs1, int vs2,
                                      bit uvd, bit uvs1, bit uvs2);
        spatz_req_t r;
        r.id      = spatz_id_t'($urandom_range(0, 3));  // must be ignored by the queue
        r.ex_unit = ex;
        r.op      = op;
        r.vd      = 5'(vd);
        r.vs1     = 5'(vs1);
        r.vs2     = 5'(vs2);
        r.use_vd  = uvd;
        r.use_vs1 = uvs1;
        r.use_vs2 = uvs2;
        r.rs1     = $urandom;
        return r;
    endfunction

    function automatic spatz_req_t rnd_req();
        return mk(ex_unit_e'($urandom_range(0, 3)), op_e'($urandom_range(0, 6)),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0);
    endfunction

    // Empty the queue and retire everything outstanding, within a cycle budget.
    task automatic drain(string name);
        int n = 0;
        bus.req_valid_i   = 1'b0;
        bus.issue_ready_i = 1'b1;
        while ((outst.size() != 0 || mq.size() != 0) && n < 300) begin
            retire_some(60);
            tick();
            n++;
        end
        clr_rsp();
        tick();
        chk({name, "_drain_in_budget"}, 64'(n < 300), 64'(1));
        @(negedge clk);
        chk({name, "_busy_after_drain"}, 64'(busy), 64'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.req_valid_i   = 1'b0;
        bus.req_i         = '0;
        bus.issue_ready_i = 1'b0;
        bus.vfu_rsp_i     = '0;
        bus.vlsu_rsp_i    = '0;
        bus.vsldu_rsp_i   = '0;
        clr_rsp();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // IDs exhausted by four held requests; the fifth is refused.
        for (int k = 0; k < 5; k++) begin
            bus.req_valid_i = 1'b1;
            bus.req_i       = mk(VFU, VADD, k, k + 8, k + 16, 1'b1, 1'b1, 1'b1);
            tick();
        end
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("t1_in_flight_4",   64'(ids_in_flight),  64'(4));
        chk("t1_ready_low",     64'(bus.req_ready_o), 64'(0));
        chk("t1_head_id0",      64'(bus.issue_o.id),  64'(0));
        drain("t1");

        // Four issued, nothing retired: blocked until id 2 comes back.
        bus.issue_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid_i = 1'b1;
            bus.req_i       = mk(VFU, VMUL, k, 1, 2, 1'b1, 1'b0, 1'b1);
            tick();
        end
        tick();
        @(negedge clk);
        chk("t2_ready_low", 64'(bus.req_ready_o), 64'(0));
        tick();
        retire_id(0, 2);
        tick();
        clr_rsp();
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_reuse_valid", 64'(bus.issue_valid_o), 64'(1));
        chk("t2_reuse_id2",   64'(bus.issue_o.id),    64'(2));
        drain("t2");

        // Three ports retire together while a request waits.
        for (int k = 0; k < 4; k++) begin
            bus.req_valid_i = 1'b1;
            bus.req_i       = mk(LSU, VLE, k + 4, 0, 0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        bus.req_valid_i = 1'b0;
        tick();
        retire_id(0, 0);
        retire_id(1, 1);
        retire_id(2, 3);
        bus.req_valid_i = 1'b1;
        bus.req_i       = mk(SLD, VSLIDEUP, 9, 0, 10, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_ready_low_in_retire_cycle", 64'(bus.req_ready_o), 64'(0));
        chk("t3_in_flight_before",          64'(ids_in_flight),   64'(4));
        tick();
        clr_rsp();
        @(negedge clk);
        chk("t3_in_flight_after", 64'(ids_in_flight),   64'(1));
        chk("t3_ready_high",      64'(bus.req_ready_o), 64'(1));
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("t3_new_id0", 64'(bus.issue_o.id), 64'(0));
        drain("t3");

        // Controller request frees its id on issue.
        bus.req_valid_i = 1'b1;
        bus.req_i       = mk(CON, VCFG, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_con_busy",      64'(busy),          64'(0));
        chk("t4_con_in_flight", 64'(ids_in_flight), 64'(0));
        tick();

        // Reset while entries are queued.
        bus.issue_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.req_valid_i = 1'b1;
            bus.req_i       = rnd_req();
            tick();
        end
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_issue_valid", 64'(bus.issue_valid_o), 64'(0));
        chk("t5_rst_in_flight",   64'(ids_in_flight),     64'(0));
        tick();
        rst_n             = 1'b1;
        bus.req_valid_i   = 1'b1;
        bus.req_i         = mk(VFU, VADD, 3, 1, 2, 1'b1, 1'b1, 1'b1);
        bus.issue_ready_i = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_first_id0", 64'(bus.issue_o.id), 64'(0));
        drain("t5");

`ifdef SPATZ_ISSUE_HAZARD_STALL_EN
        // Read-after-write on v4 stalls until the load retires.
        bus.req_valid_i = 1'b1;
        bus.req_i       = mk(LSU, VLE, 4, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.req_i = mk(VFU, VADD, 6, 1, 4, 1'b1, 1'b0, 1'b1);
        tick();
        bus.req_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_stall", 64'(bus.issue_valid_o), 64'(0));
            tick();
        end
        retire_id(1, 0);
        @(negedge clk);
        chk("t6_stall_retire_cycle", 64'(bus.issue_valid_o), 64'(0));
        tick();
        clr_rsp();
        @(negedge clk);
        chk("t6_release", 64'(bus.issue_valid_o), 64'(1));
        drain("t6a");
        bus.req_valid_i = 1'b1;
        bus.req_i       = mk(LSU, VLE, 4, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.req_i = mk(VFU, VADD, 6, 1, 5, 1'b1, 1'b0, 1'b1);
        tick();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("t6_no_stall", 64'(bus.issue_valid_o), 64'(1));
        drain("t6b");
`endif

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            bus.req_valid_i   = $urandom_range(0, 99) < 60;
            bus.req_i         = rnd_req();
            bus.issue_ready_i = $urandom_range(0, 99) < 70;
            retire_some(30);
            tick();
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
